reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//   Writeback stage directly upstream of reg_file: merges ALU results and load results onto
//   reg_file's single write port (wr_req/wr_sel/wr_data).
//   - ALU results have priority.
//   - Load results are buffered in a small FIFO.
//   - A starvation counter guarantees that buffered loads drain.
//   - Optional read bypass covers the one-cycle gap before a registered write becomes visible.
// PARAMETERS
//   data_width       32  register data width
//   reg_sel_width     5  register select width (32 regs, x0 hardwired zero)
//   load_fifo_depth   4  load result FIFO entries (power of 2, >=2)
//   starve_limit      3  consecutive lost arbitrations before a load is forced through (>=1)
// PORTS
//   clk          in   1              clock, all state on posedge
//   rst          in   1              synchronous reset, active-low (0 = reset)
//   alu_valid    in   1              ALU result present this cycle
//   alu_ready    out  1              ALU result accepted when alu_valid & alu_ready
//   alu_rd_sel   in   reg_sel_width  ALU destination register
//   alu_data     in   data_width     ALU result
//   load_valid   in   1              load result present
//   load_ready   out  1              load FIFO can accept (push = load_valid & load_ready)
//   load_rd_sel  in   reg_sel_width  load destination register
//   load_data    in   data_width     load data
//   wr_req       out  1              to reg_file write enable (registered)
//   wr_sel       out  reg_sel_width  to reg_file write select (registered)
//   wr_data      out  data_width     to reg_file write data (registered)
//   rs1_sel      in   reg_sel_width  read selects, same as driven into reg_file
//   rs2_sel      in   reg_sel_width
//   rf_rs1_data  in   data_width     raw reg_file read data
//   rf_rs2_data  in   data_width
//   rs1_data     out  data_width     read data to consumers (see CONFIGURATION)
//   rs2_data     out  data_width
// BEHAVIOUR
//   - Reset (rst==0 at posedge): FIFO emptied, starve_cnt=0, wr_req=0, wr_sel=0, wr_data=0.
//     While rst==0, alu_ready=0 and load_ready=0.
//   - load_ready = (count != load_fifo_depth), from registered count. A pop in the same cycle
//     does not raise load_ready that cycle.
//     Push and pop in the same cycle: count unchanged, FIFO order preserved.
//   - alu_ready = (starve_cnt != starve_limit).
//   - Arbitration, once per cycle:
//     - If alu_valid & alu_ready: select ALU.
//       If the FIFO is non-empty, starve_cnt++; otherwise starve_cnt=0.
//     - Else if the FIFO is non-empty: pop the head, select the load, starve_cnt=0.
//     - Else: nothing selected, starve_cnt=0.
//   - Forced drain: when starve_cnt==starve_limit, alu_ready=0, so the FIFO head pops that
//     cycle. ALU must hold its result.
//   - Latency: the selected result appears on wr_* at the next posedge (1 cycle).
//     reg_file commits it at the following posedge.
//   - x0: a selected result with rd_sel==0 is consumed (ALU accepted / FIFO popped) but
//     drives wr_req=0 next cycle.
//   - wr_req=0 whenever nothing is selected. wr_sel and wr_data hold their last values when
//     wr_req=0.
//   - Reset mid-operation: buffered loads are discarded. An in-flight wr_req is cleared
//     without being written.
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     - rsN_data = wr_data when wr_req & (wr_sel==rsN_sel) & (rsN_sel!=0); otherwise rf_rsN_data.
//     - The bypass is combinational, so consumers see the pending write in the same cycle.
//   WB_BYPASS_EN undefined:
//     - rsN_data = rf_rsN_data (pure passthrough).
//     - Ports are unchanged, so the bench is shared between both builds.
// TESTING
//   1 Reset: hold rst=0 for 2 cycles with alu_valid=1 -> wr_req=0, alu_ready=0, load_ready=0.
//   2 ALU only: alu_valid=1, alu_rd_sel=3, alu_data=111 -> next cycle wr_req=1, wr_sel=3,
//     wr_data=111. reg_file rs1_sel=3 reads 111 one cycle later.
//   3 FIFO full: 4 loads (rd=7, data 222..225) with alu_valid held 1 -> load_ready=0 after
//     the 4th push. With starve_limit=3, alu_ready=0 every 4th cycle. The loads write in
//     order 222, 223, 224, 225.
//   4 x0 drop: alu_rd_sel=0, alu_data=55 -> alu_ready=1, no wr_req. reg 0 still reads 0.
//   5 WB_BYPASS_EN: wr_req=1, wr_sel=7, wr_data=222 with rs2_sel=7, rf_rs2_data=0 ->
//     rs2_data=222 in the same cycle. rs1_sel=0 -> rs1_data=rf_rs1_data.
//   6 Mid-op reset: 2 loads buffered, rst=0 for 1 cycle -> FIFO empty, no further wr_req
//     for those loads.

Source files
------------

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: ALU/load result inputs, reg_file write port and read-bypass signals of the writeback stage
interface reg_writeback_if #(
  parameter int data_width    = 32,
  parameter int reg_sel_width = 5
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [reg_sel_width-1:0] alu_rd_sel;
  logic [data_width-1:0]    alu_data;
  logic                     load_valid;
  logic                     load_ready;
  logic [reg_sel_width-1:0] load_rd_sel;
  logic [data_width-1:0]    load_data;
  logic                     wr_req;
  logic [reg_sel_width-1:0] wr_sel;
  logic [data_width-1:0]    wr_data;
  logic [reg_sel_width-1:0] rs1_sel;
  logic [reg_sel_width-1:0] rs2_sel;
  logic [data_width-1:0]    rf_rs1_data;
  logic [data_width-1:0]    rf_rs2_data;
  logic [data_width-1:0]    rs1_data;
  logic [data_width-1:0]    rs2_data;
  modport master (
    output alu_valid, alu_rd_sel, alu_data, load_valid, load_rd_sel, load_data,
           rs1_sel, rs2_sel, rf_rs1_data, rf_rs2_data,
    input  alu_ready, load_ready, wr_req, wr_sel, wr_data, rs1_data, rs2_data
  );
  modport slave (
    input  alu_valid, alu_rd_sel, alu_data, load_valid, load_rd_sel, load_data,
           rs1_sel, rs2_sel, rf_rs1_data, rf_rs2_data,
    output alu_ready, load_ready, wr_req, wr_sel, wr_data, rs1_data, rs2_data
  );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and buffered load results onto reg_file's write port; WB_BYPASS_EN adds read bypass
module reg_writeback #(
  parameter int data_width      = 32,
  parameter int reg_sel_width   = 5,
  parameter int load_fifo_depth = 4,
  parameter int starve_limit    = 3
) (
  input logic           clk,
  input logic           rst,
  reg_writeback_if.slave bus
);
  localparam int aw = $clog2(load_fifo_depth);
  localparam int cw = aw + 1;
  localparam int sw = $clog2(starve_limit + 1);
  typedef struct packed {
    logic [reg_sel_width-1:0] sel;
    logic [data_width-1:0]    data;
  } ent_t;
  ent_t                     mem_q [load_fifo_depth];
  ent_t                     mem_d [load_fifo_depth];
  logic [aw-1:0]            rd_q, rd_d, wp_q, wp_d;
  logic [cw-1:0]            cnt_q, cnt_d;
  logic [sw-1:0]            starve_q, starve_d;
  logic                     wr_req_q, wr_req_d;
  logic [reg_sel_width-1:0] wr_sel_q, wr_sel_d;
  logic [data_width-1:0]    wr_data_q, wr_data_d;
  logic                     alu_ready, load_ready, alu_take, push, pop, nonempty;
  ent_t                     head, pick;
  // arbitration: ALU first unless the load FIFO has starved starve_limit times, then pop the head
  always_comb begin
    alu_ready  = rst && (starve_q != sw'(starve_limit));
    load_ready = rst && (cnt_q != cw'(load_fifo_depth));
    nonempty   = cnt_q != '0;
    alu_take   = bus.alu_valid && alu_ready;
    push       = bus.load_valid && load_ready;
    pop        = !alu_take && nonempty;
    head       = mem_q[rd_q];
    pick       = alu_take ? ent_t'{bus.alu_rd_sel, bus.alu_data} : head;
    starve_d   = (alu_take && nonempty) ? starve_q + sw'(1) : '0;
    wr_req_d   = (alu_take || pop) && (pick.sel != '0);
    wr_sel_d   = wr_req_d ? pick.sel : wr_sel_q;
    wr_data_d  = wr_req_d ? pick.data : wr_data_q;
    mem_d      = mem_q;
    if (push) mem_d[wp_q] = ent_t'{bus.load_rd_sel, bus.load_data};
    wp_d       = wp_q + aw'(push);
    rd_d       = rd_q + aw'(pop);
    cnt_d      = cnt_q + cw'(push) - cw'(pop);
  end
  // control state and the registered write port; reset drops buffered loads and any in-flight write
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      rd_q      <= '0;
      wp_q      <= '0;
      starve_q  <= '0;
      wr_req_q  <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wp_q      <= wp_d;
      starve_q  <= starve_d;
      wr_req_q  <= wr_req_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
    end
  end
  // FIFO storage needs no reset: entries are only read while counted
  always_ff @(posedge clk) mem_q <= mem_d;
  assign bus.alu_ready  = alu_ready;
  assign bus.load_ready = load_ready;
  assign bus.wr_req     = wr_req_q;
  assign bus.wr_sel     = wr_sel_q;
  assign bus.wr_data    = wr_data_q;
`ifdef WB_BYPASS_EN
  assign bus.rs1_data = (wr_req_q && wr_sel_q == bus.rs1_sel && bus.rs1_sel != '0) ? wr_data_q : bus.rf_rs1_data;
  assign bus.rs2_data = (wr_req_q && wr_sel_q == bus.rs2_sel && bus.rs2_sel != '0) ? wr_data_q : bus.rf_rs2_data;
`else
  assign bus.rs1_data = bus.rf_rs1_data;
  assign bus.rs2_data = bus.rf_rs2_data;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scoreboard bench for reg_writeback with a reg_file model behind the write port
module tb_reg_writeback;
`ifdef WB_BYPASS_EN
  localparam bit byp = 1'b1;
`else
  localparam bit byp = 1'b0;
`endif
  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  reg_writeback_if bus ();
  reg_writeback dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] rf [32] = '{default: '0};
  ent_t exp_q[$];
  ent_t lf_q[$];
  int   total = 0;
  int   bad = 0;
  int   starve_m = 0;
  bit   acc;
  always @(posedge clk) if (bus.wr_req && bus.wr_sel != 5'd0) rf[bus.wr_sel] <= bus.wr_data;
  assign bus.rf_rs1_data = rf[bus.rs1_sel];
  assign bus.rf_rs2_data = rf[bus.rs2_sel];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic step();
    ent_t e;
    bit   have, ar, lr, take;
    e = '0;
    @(negedge clk);
    have = exp_q.size() > 0;
    chk("wr_req", {31'd0, bus.wr_req}, {31'd0, have});
    if (have) begin
      e = exp_q.pop_front();
      chk("wr_sel", {27'd0, bus.wr_sel}, {27'd0, e.sel});
      chk("wr_data", bus.wr_data, e.data);
    end
    chk("rs1_data", bus.rs1_data, (byp && have && e.sel == bus.rs1_sel && bus.rs1_sel != 5'd0) ? e.data : bus.rf_rs1_data);
    chk("rs2_data", bus.rs2_data, (byp && have && e.sel == bus.rs2_sel && bus.rs2_sel != 5'd0) ? e.data : bus.rf_rs2_data);
    ar = rst && starve_m != 3;
    lr = rst && lf_q.size() != 4;
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, ar});
    chk("load_ready", {31'd0, bus.load_ready}, {31'd0, lr});
    take = bus.alu_valid && ar;
    acc = take;
    if (!rst) begin
      lf_q.delete();
      starve_m = 0;
    end else begin
      if (take) begin
        if (bus.alu_rd_sel != 5'd0) exp_q.push_back(ent_t'{bus.alu_rd_sel, bus.alu_data});
        starve_m = lf_q.size() > 0 ? starve_m + 1 : 0;
      end else begin
        if (lf_q.size() > 0) begin
          e = lf_q.pop_front();
          if (e.sel != 5'd0) exp_q.push_back(e);
        end
        starve_m = 0;
      end
      if (bus.load_valid && lr) lf_q.push_back(ent_t'{bus.load_rd_sel, bus.load_data});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.alu_valid   = 1'b1;
    bus.alu_rd_sel  = 5'd3;
    bus.alu_data    = 32'd111;
    bus.load_valid  = 1'b0;
    bus.load_rd_sel = 5'd0;
    bus.load_data   = 32'd0;
    bus.rs1_sel     = 5'd0;
    bus.rs2_sel     = 5'd0;
    step();
    step();
    chk("rst_wr_sel", {27'd0, bus.wr_sel}, 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    rst = 1'b1;
    step();
    bus.alu_valid = 1'b0;
    step();
    bus.rs1_sel = 5'd3;
    #1;
    chk("rd3_after_commit", bus.rs1_data, 32'd111);
    bus.alu_valid   = 1'b1;
    bus.alu_rd_sel  = 5'd5;
    bus.alu_data    = 32'd1000;
    bus.load_valid  = 1'b1;
    bus.load_rd_sel = 5'd7;
    bus.rs2_sel     = 5'd7;
    for (int i = 0; i < 4; i++) begin
      bus.load_data = 32'(222 + i);
      step();
      if (acc) bus.alu_data = bus.alu_data + 32'd1;
    end
    bus.load_valid = 1'b0;
    chk("fifo_full", {31'd0, bus.load_ready}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      if (acc) bus.alu_data = bus.alu_data + 32'd1;
    end
    bus.alu_valid = 1'b0;
    step();
    step();
    chk("rd7_last_load", bus.rs2_data, 32'd225);
    bus.alu_valid  = 1'b1;
    bus.alu_rd_sel = 5'd0;
    bus.alu_data   = 32'd55;
    step();
    bus.alu_valid = 1'b0;
    step();
    step();
    bus.rs1_sel = 5'd0;
    #1;
    chk("x0_reads_zero", bus.rs1_data, 32'd0);
    bus.rs2_sel     = 5'd9;
    bus.load_valid  = 1'b1;
    bus.load_rd_sel = 5'd9;
    bus.load_data   = 32'd333;
    step();
    bus.load_valid = 1'b0;
    step();
    step();
    step();
    bus.alu_valid   = 1'b1;
    bus.alu_rd_sel  = 5'd4;
    bus.alu_data    = 32'd77;
    bus.load_valid  = 1'b1;
    bus.load_rd_sel = 5'd12;
    bus.load_data   = 32'd444;
    step();
    bus.alu_data  = 32'd78;
    bus.load_data = 32'd445;
    step();
    bus.load_valid = 1'b0;
    bus.alu_valid  = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    step();
    bus.rs1_sel = 5'd12;
    #1;
    chk("flushed_load_reg", bus.rs1_data, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
